// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the shared instruction/data memory.
// Port 0 is the processor core, port 1 is the host loader / debug port. One
// access is in flight at a time; each transfer takes MEM_LAT + 2 cycles.
// MEM_LAT must lie in 1..15 (the down-counter is 4 bits wide).
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                win_q;        // port owning the current transfer
  logic                last_srv_q;   // port served by the previous transfer
  logic                cmd_we_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                take;         // accept a request on this edge
  logic                sel;          // winner if a request is accepted
  logic                last_access;  // final ACCESS cycle

  assign last_access = (state_q == StAccess) && (cnt_q == 4'd1);

  // Arbitration and next-state decode; ties go to the port not served last.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    sel     = (req0 && req1) ? ~last_srv_q : req1;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          take    = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Command latch and latency counter, loaded when a request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= 4'd0;
    end else if (take) begin
      win_q       <= sel;
      cmd_we_q    <= sel ? we1 : we0;
      cmd_addr_q  <= sel ? addr1 : addr0;
      cmd_wdata_q <= sel ? wdata1 : wdata0;
      cnt_q       <= LatCnt;
    end else if (state_q == StAccess) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Round-robin history; reset value hands the first tie to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last_srv_q <= 1'b1;
    else if (state_q == StDone) last_srv_q <= win_q;
  end

  // Read data capture at the end of the last ACCESS cycle; writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (last_access && !cmd_we_q) begin
      if (win_q) rdata1_q <= mem_rdata;
      else       rdata0_q <= mem_rdata;
    end
  end

  // Output decode from state and the latched command.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = (state_q != StIdle);
    mem_addr  = cmd_addr_q;
    mem_wdata = cmd_wdata_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
    if (state_q == StAccess) begin
      mem_en = 1'b1;
      mem_we = cmd_we_q;
    end
    if (state_q != StIdle) begin
      gnt0 = ~win_q;
      gnt1 = win_q;
    end
    if (state_q == StDone) begin
      done0 = ~win_q;
      done1 = win_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT = 2 and a simple memory model.
module tb_mem_arbiter;

  localparam int unsigned Lat = 2;

  logic       clk, rst;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;

  logic [7:0] mem [32];

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(Lat)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(16 + i);
    mem[3] = 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       r0, w0;
    logic [4:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [4:0] a1;
    logic [7:0] d1;
    logic       win;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from an IDLE cycle; leaves the bench in a following IDLE cycle.
  task automatic run_vec(input vec_t v, input int i);
    logic [4:0] ea;
    logic [7:0] ed;
    logic       ew;
    ea = v.win ? v.a1 : v.a0;
    ed = v.win ? v.d1 : v.d0;
    ew = v.win ? v.w1 : v.w0;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    for (int k = 0; k < int'(Lat); k++) begin
      step();
      chk($sformatf("v%0d acc%0d mem_en", i, k), 32'(mem_en), 32'd1);
      chk($sformatf("v%0d acc%0d mem_we", i, k), 32'(mem_we), 32'(ew));
      chk($sformatf("v%0d acc%0d mem_addr", i, k), 32'(mem_addr), 32'(ea));
      if (ew) chk($sformatf("v%0d acc%0d mem_wdata", i, k), 32'(mem_wdata), 32'(ed));
      chk($sformatf("v%0d acc%0d gnt", i, k), 32'({gnt1, gnt0}), v.win ? 32'd2 : 32'd1);
      chk($sformatf("v%0d acc%0d done", i, k), 32'({done1, done0}), 32'd0);
    end
    step();
    chk($sformatf("v%0d done", i), 32'({done1, done0}), v.win ? 32'd2 : 32'd1);
    chk($sformatf("v%0d done gnt", i), 32'({gnt1, gnt0}), v.win ? 32'd2 : 32'd1);
    chk($sformatf("v%0d done mem_en", i), 32'({mem_en, mem_we}), 32'd0);
    chk($sformatf("v%0d rdata0", i), 32'(rdata0), 32'(v.rd0));
    chk($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(v.rd1));
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk($sformatf("v%0d idle busy", i), 32'({busy, gnt1, gnt0, done1, done0}), 32'd0);
  endtask

  int         n_done, bad, cnt;
  logic       order [6];
  int         cyc [6];
  logic       pd0, pd1;

  initial begin
    //            r0    w0    a0     d0     r1    w1    a1     d1     win   rd0    rd1
    vecs[0] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'hC3, 1'b1, 8'h5A, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'hC3, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 8'h99, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 8'h99, 8'h5A};
    vecs[5] = '{1'b1, 1'b1, 5'd2, 8'h77, 1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 8'h99, 8'h5A};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00, 1'b1, 8'h99, 8'h77};
    vecs[7] = '{1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd4, 8'hAB, 1'b0, 8'h10, 8'h77};

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    step(); step();
    chk("reset ctl", 32'({gnt0, gnt1, done0, done1, mem_en, mem_we, busy}), 32'd0);
    chk("reset bus", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("reset rdata", 32'({rdata0, rdata1}), 32'd0);
    rst = 1'b0;
    step();
    chk("idle busy", 32'(busy), 32'd0);

    // Tie right after reset: core first, host follows one IDLE cycle after done0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd9; wdata1 = 8'h99;
    step();
    chk("tie gnt t+1", 32'({gnt1, gnt0}), 32'd1);
    step();
    step();
    chk("tie done0", 32'({done1, done0}), 32'd1);
    chk("tie rdata0", 32'(rdata0), 32'h5A);
    req0 = 1'b0;
    step();
    chk("tie idle", 32'({busy, gnt1}), 32'd0);
    step();
    chk("tie gnt1", 32'({gnt1, gnt0}), 32'd2);
    chk("tie host we", 32'({mem_we, mem_addr}), 32'({1'b1, 5'd9}));
    step();
    step();
    chk("tie done1", 32'({done1, done0}), 32'd2);
    chk("tie rdata1 after write", 32'(rdata1), 32'd0);
    req1 = 1'b0;
    step();
    chk("tie end busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both ports held high for six transfers after a fresh reset.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
    n_done = 0; bad = 0; pd0 = 1'b0; pd1 = 1'b0;
    for (int c = 0; c < 40 && n_done < 6; c++) begin
      step();
      if ((done0 && pd0) || (done1 && pd1) || (done0 && done1)) bad++;
      pd0 = done0;
      pd1 = done1;
      if (done0 || done1) begin
        order[n_done] = done1;
        cyc[n_done]   = c;
        n_done++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("alt count", 32'(n_done), 32'd6);
    for (int i = 0; i < n_done; i++) chk($sformatf("alt order%0d", i), 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < n_done; i++)
      chk($sformatf("alt spacing%0d", i), 32'(cyc[i] - cyc[i-1]), 32'(Lat + 2));
    chk("alt pulse width", 32'(bad), 32'd0);
    chk("alt rdata", 32'({rdata0, rdata1}), 32'h115A);
    step();

    // Reset in the second ACCESS cycle of a core read aborts it without a done.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3; wdata0 = 8'hEE;
    step();
    chk("abort gnt0", 32'(gnt0), 32'd1);
    step();
    chk("abort acc2", 32'({mem_en, mem_addr}), 32'({1'b1, 5'd3}));
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("abort ctl", 32'({gnt0, gnt1, done0, done1, mem_en, mem_we, busy}), 32'd0);
    chk("abort bus", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("abort rdata", 32'({rdata0, rdata1}), 32'd0);
    cnt = 0;
    step();
    cnt += int'(done0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      cnt += int'(done0) + int'(busy);
    end
    chk("abort no done", 32'(cnt), 32'd0);
    run_vec('{1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 8'h00, 8'h5A}, 8);

    // Host drops req1 mid-access; core req0 glitch during the transfer is ignored.
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    step();
    chk("drop gnt1", 32'({gnt1, gnt0}), 32'd2);
    req1 = 1'b0;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("drop acc2", 32'({gnt1, gnt0, mem_en}), 32'b101);
    step();
    chk("drop done1", 32'({done1, done0}), 32'd2);
    chk("drop rdata1", 32'(rdata1), 32'h77);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      cnt += int'(busy) + int'(gnt0) + int'(gnt1) + int'(done0) + int'(done1);
    end
    chk("drop stays idle", 32'(cnt), 32'd0);
    req1 = 1'b1;
    step();
    chk("drop new req1", 32'({gnt1, gnt0}), 32'd2);
    req1 = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("final idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
